// File: rtl/cpu_display_scan.sv
// cpu_display_scan: 8-digit common-anode seven-segment scanner for CPU display/cycle_count; macro CPU_DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zeros
module cpu_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] display,
    input  logic [31:0] cycle_count,
    input  logic        halt,
    input  logic        sel_cycle,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [31:0] value_shown,
    output logic        halted
);
    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  IDX_LAST = 3'(DIGITS - 1);
    localparam logic [6:0]  HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [15:0] div_cnt;
    logic [2:0]  idx;
    logic [31:0] disp_snap, cyc_snap;
    logic        tick, frame_start, load, blank;
    logic [3:0]  nibble;

    assign tick        = div_cnt == DIV_LAST;
    assign frame_start = tick && idx == IDX_LAST;
    assign load        = !halted && (halt || frame_start);
    assign value_shown = sel_cycle ? cyc_snap : disp_snap;
    assign nibble      = value_shown[{idx, 2'b00} +: 4];
`ifdef CPU_DISPLAY_LEADING_ZERO_BLANK_EN
    // a digit is blank when it and every more-significant nibble are zero; digit 0 always shows
    assign blank = idx != 3'd0 && (value_shown >> {idx, 2'b00}) == 32'd0;
`else
    assign blank = 1'b0;
`endif

    // per-digit dwell divider and digit index
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 16'd1;
            idx     <= tick ? idx + 3'd1 : idx;
        end
    end

    // snapshot once per frame, or immediately on the first halt, then freeze until reset
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            disp_snap <= '0;
            cyc_snap  <= '0;
            halted    <= 1'b0;
        end else if (load) begin
            disp_snap <= display;
            cyc_snap  <= cycle_count;
            halted    <= halt;
        end
    end

    // registered anode/segment drive; dp of digit 0 marks a halted CPU
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'd1 << idx);
            seg <= {~(halted && idx == 3'd0), blank ? 7'h7F : HEX7[nibble]};
        end
    end
endmodule

// File: tb/tb_cpu_display_scan.sv
// tb_cpu_display_scan: randomized scoreboard bench for cpu_display_scan against a cycle-count reference model
module tb_cpu_display_scan;
    localparam int S = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7:0]  an;
        logic [7:0]  seg;
        logic [31:0] val;
        logic        halted;
    } exp_t;

    logic        clk = 1'b0, clr = 1'b1, halt = 1'b0, sel_cycle = 1'b0, rs = 1'b0;
    logic [31:0] display = '0, cycle_count = '0, value_shown;
    logic [7:0]  an, seg;
    logic        halted;
    int          tests = 0, fails = 0;
    exp_t        q[$];
    exp_t        me;
    int unsigned cyc = 0;
    logic [31:0] m_disp = '0, m_cyc = '0;
    logic        m_halt = 1'b0;

    cpu_display_scan #(.SCAN_DIV(S), .DIGITS(8)) dut (
        .clk(clk), .clr(clr), .display(display), .cycle_count(cycle_count),
        .halt(halt), .sel_cycle(sel_cycle), .an(an), .seg(seg),
        .value_shown(value_shown), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // expected segment byte for digit d of value v, from the glyph table and the blanking rule
    function automatic logic [7:0] seg_for(int d, logic [31:0] v, logic hl);
        logic [31:0] sh;
        logic [6:0]  g;
        sh = v >> (4 * d);
        g  = GLYPH[sh[3:0]];
`ifdef CPU_DISPLAY_LEADING_ZERO_BLANK_EN
        if (d > 0 && sh == 32'd0) g = 7'h7F;
`endif
        return {~(hl && d == 0), g};
    endfunction

    // drive one cycle's inputs, predict the outputs after the coming edge, then advance
    task automatic step(logic [31:0] dv, logic [31:0] cv, logic h, logic s);
        exp_t e;
        int   d;
        display = dv; cycle_count = cv; halt = h; sel_cycle = s;
        d = int'((cyc / S) % 8);
        e.an  = ~(8'd1 << d);
        e.seg = seg_for(d, s ? m_cyc : m_disp, m_halt);
        if (!m_halt && (h || (cyc + 1) % (8 * S) == 0)) begin
            m_disp = dv;
            m_cyc  = cv;
            m_halt = h;
        end
        cyc++;
        e.val    = s ? m_cyc : m_disp;
        e.halted = m_halt;
        q.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; #1;
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_value", value_shown, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk); #1;
        clr = 1'b0;
        cyc = 0; m_disp = '0; m_cyc = '0; m_halt = 1'b0;
    endtask

    // monitor: each output cycle is compared against the oldest prediction
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            me = q.pop_front();
            check("an", {24'd0, an}, {24'd0, me.an});
            check("seg", {24'd0, seg}, {24'd0, me.seg});
            check("value_shown", value_shown, me.val);
            check("halted", {31'd0, halted}, {31'd0, me.halted});
        end
    end

    initial begin
        @(negedge clk); #1;
        do_reset();
        repeat (16 * S) step(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3 * S + 1) step(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (16 * S) step(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        repeat (S + 2) step(32'hDEAD_BEEF, 32'd100, 1'b0, 1'b0);
        step(32'hDEAD_BEEF, 32'd100, 1'b1, 1'b0);
        repeat (24 * S) step(32'd0, 32'd200, 1'b0, 1'b0);
        check("halt_value", value_shown, 32'hDEAD_BEEF);
        repeat (2 * S) step(32'd0, 32'd200, 1'b0, 1'b1);
        check("halt_sel_value", value_shown, 32'h0000_0064);
        while ((cyc / S) % 8 != 5) step(32'd0, 32'd200, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            if (i % 300 == 299) do_reset();
            if ($urandom_range(7) == 0) rs = 1'($urandom_range(1));
            step($urandom, $urandom, $urandom_range(199) == 0, rs);
        end
        do_reset();
        repeat (16 * S) step(32'h0000_00A0, 32'd0, 1'b0, 1'b0);
        repeat (16 * S) step(32'd0, 32'd0, 1'b0, 1'b0);
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
